ram_io_nibble_packer: RTL and testbench

//  Downstream of the RAM_IO 4-bit registered/bypass output BEL. Consumes its 4-bit external output stream plus a valid strobe.

---
 rtl/ram_io_pkg.sv | 16 +
 rtl/ram_io_word_slot.sv | 40 ++++
 rtl/ram_io_nibble_packer.sv | 110 +++++++++++
 tb/tb_ram_io_nibble_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_pkg.sv
// rtl/ram_io_pkg.sv - shared constants, FSM state codes and nibble slot helper for the RAM_IO packer
package ram_io_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] EMPTY      = 2'd0;
  localparam logic [1:0] FULL       = 2'd1;
  localparam logic [1:0] FLUSH_PEND = 2'd2;

  // Bit offset of nibble k inside a word of `nibbles` nibbles.
  function automatic int unsigned nib_slot(input int unsigned k, input logic msbFirst,
                                           input int unsigned nibbles);
    return msbFirst ? (nibbles - 1 - k) * NIB_W : k * NIB_W;
  endfunction

endpackage

// File: rtl/ram_io_word_slot.sv
// rtl/ram_io_word_slot.sv - one-entry valid/ready output register with auto-incrementing write address
module ram_io_word_slot #(
  parameter int W      = 32,
  parameter int ADDR_W = 10
) (
  input  logic              UserCLK,
  input  logic              UserRST,
  input  logic              load,
  input  logic [W-1:0]      loadData,
  input  logic              incEn,
  input  logic              wr_ready,
  output logic [W-1:0]      wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid
);

  logic handshake;

  assign handshake = wr_valid && wr_ready;

  // A load on the handshake edge keeps wr_valid high, giving back-to-back words.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      wr_data  <= '0;
      wr_addr  <= '0;
      wr_valid <= 1'b0;
    end else begin
      if (handshake && incEn) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
      if (load) begin
        wr_data  <= loadData;
        wr_valid <= 1'b1;
      end else if (handshake) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_io_nibble_packer.sv
// rtl/ram_io_nibble_packer.sv - packs the RAM_IO BEL nibble stream into words for a top-level RAM write port
module ram_io_nibble_packer
  import ram_io_pkg::*;
#(
  parameter int NIBBLES      = 8,
  parameter int ADDR_W       = 10,
  parameter int NoConfigBits = 2
) (
  input  logic                     UserCLK,
  input  logic                     UserRST,
  input  logic [NIB_W-1:0]         I,
  input  logic                     I_valid,
  input  logic                     flush,
  input  logic [NoConfigBits-1:0]  ConfigBits,
  output logic [NIB_W*NIBBLES-1:0] wr_data,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] nibCnt, cntNext;
  logic [W-1:0]     asmReg, asmNext;
  logic             pending, slotFree, isLast;
  logic             accept, drop, wordDone, flushReq, load;

  assign pending  = (state == FLUSH_PEND);
  assign slotFree = !wr_valid || wr_ready;
  assign isLast   = (nibCnt == CNT_W'(NIBBLES - 1));
  assign busy     = (nibCnt != '0);

  always_comb begin
    asmNext  = asmReg;
    cntNext  = nibCnt;
    accept   = 1'b0;
    drop     = 1'b0;
    wordDone = 1'b0;
    flushReq = 1'b0;
    load     = 1'b0;
    if (pending) begin
      // The partial word owns the assembly register until it is emitted.
      drop = I_valid;
      load = slotFree;
    end else begin
      accept = I_valid && (!isLast || slotFree);
      drop   = I_valid && !accept;
      if (accept) begin
        asmNext = asmReg | (W'(I) << nib_slot(32'(nibCnt), ConfigBits[0], NIBBLES));
        cntNext = isLast ? '0 : nibCnt + CNT_W'(1);
      end
      wordDone = accept && isLast;
      // A flush coinciding with the completing nibble is a single emission.
      flushReq = flush && !wordDone && (busy || accept);
      load     = wordDone || (flushReq && slotFree);
    end
  end

  always_comb begin
    stateNext = state;
    if (load) begin
      stateNext = FULL;
    end else if (pending || flushReq) begin
      stateNext = FLUSH_PEND;
    end else if (wr_valid && wr_ready) begin
      stateNext = EMPTY;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      state    <= EMPTY;
      nibCnt   <= '0;
      asmReg   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= stateNext;
      if (load) begin
        asmReg <= '0;
        nibCnt <= '0;
      end else begin
        asmReg <= asmNext;
        nibCnt <= cntNext;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  ram_io_word_slot #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_slot (
    .UserCLK  (UserCLK),
    .UserRST  (UserRST),
    .load     (load),
    .loadData (asmNext),
    .incEn    (ConfigBits[1]),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .wr_valid (wr_valid)
  );

endmodule

// File: tb/tb_ram_io_nibble_packer.sv
// tb/tb_ram_io_nibble_packer.sv - directed self-checking bench for ram_io_nibble_packer
module tb_ram_io_nibble_packer;

  logic        UserCLK = 1'b0;
  logic        UserRST;
  logic [3:0]  I;
  logic        I_valid;
  logic        flush;
  logic [1:0]  ConfigBits;
  logic [31:0] wr_data;
  logic [9:0]  wr_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        overflow;

  int checkCnt = 0;
  int passCnt  = 0;

  always #5 UserCLK = ~UserCLK;

  ram_io_nibble_packer #(
    .NIBBLES      (8),
    .ADDR_W       (10),
    .NoConfigBits (2)
  ) dut (
    .UserCLK    (UserCLK),
    .UserRST    (UserRST),
    .I          (I),
    .I_valid    (I_valid),
    .flush      (flush),
    .ConfigBits (ConfigBits),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCnt++;
    if (actual === expected) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic sendNib(input logic [3:0] n);
    I       = n;
    I_valid = 1'b1;
    tick();
    I_valid = 1'b0;
  endtask

  task automatic doReset();
    UserRST = 1'b1;
    I_valid = 1'b0;
    flush   = 1'b0;
    tick();
    UserRST = 1'b0;
  endtask

  initial begin
    I          = 4'h0;
    I_valid    = 1'b0;
    flush      = 1'b0;
    wr_ready   = 1'b1;
    ConfigBits = 2'b10;
    UserRST    = 1'b1;
    tick();
    doReset();
    checkVal("rst_data", wr_data, 32'h0);
    checkVal("rst_addr", 32'(wr_addr), 32'h0);
    checkVal("rst_valid", 32'(wr_valid), 32'h0);
    checkVal("rst_busy", 32'(busy), 32'h0);
    checkVal("rst_ovf", 32'(overflow), 32'h0);

    // LSB-first word, one-cycle latency after the last nibble
    for (int k = 0; k < 7; k++) sendNib(4'(k + 1));
    checkVal("t1_valid_early", 32'(wr_valid), 32'h0);
    checkVal("t1_busy", 32'(busy), 32'h1);
    sendNib(4'h8);
    checkVal("t1_valid", 32'(wr_valid), 32'h1);
    checkVal("t1_data", wr_data, 32'h87654321);
    checkVal("t1_addr", 32'(wr_addr), 32'h0);
    checkVal("t1_busy_clr", 32'(busy), 32'h0);
    tick();
    checkVal("t1_drained", 32'(wr_valid), 32'h0);
    checkVal("t1_addr_inc", 32'(wr_addr), 32'h1);

    // MSB-first, two consecutive words
    doReset();
    ConfigBits = 2'b11;
    for (int k = 0; k < 8; k++) sendNib(4'(k + 1));
    checkVal("t2_data", wr_data, 32'h12345678);
    checkVal("t2_addr", 32'(wr_addr), 32'h0);
    for (int k = 0; k < 8; k++) begin
      sendNib(4'(k + 9));
      if (k == 0) checkVal("t2_gap_addr", 32'(wr_addr), 32'h1);
    end
    checkVal("t2_valid2", 32'(wr_valid), 32'h1);
    checkVal("t2_data2", wr_data, 32'h9ABCDEF0);
    checkVal("t2_addr2", 32'(wr_addr), 32'h1);

    // Backpressure: held word stable, back-to-back load on release, then overflow
    doReset();
    ConfigBits = 2'b10;
    wr_ready   = 1'b0;
    for (int k = 0; k < 8; k++) sendNib(4'(k + 1));
    for (int k = 0; k < 7; k++) sendNib(4'(k + 9));
    checkVal("t3_hold_data", wr_data, 32'h87654321);
    checkVal("t3_hold_addr", 32'(wr_addr), 32'h0);
    checkVal("t3_hold_valid", 32'(wr_valid), 32'h1);
    checkVal("t3_no_ovf", 32'(overflow), 32'h0);
    wr_ready = 1'b1;
    sendNib(4'h0);
    checkVal("t3_b2b_valid", 32'(wr_valid), 32'h1);
    checkVal("t3_b2b_data", wr_data, 32'h0FEDCBA9);
    checkVal("t3_b2b_addr", 32'(wr_addr), 32'h1);
    wr_ready = 1'b0;
    for (int k = 0; k < 7; k++) sendNib(4'h1);
    checkVal("t3_pre_ovf", 32'(overflow), 32'h0);
    sendNib(4'h1);
    checkVal("t3_ovf", 32'(overflow), 32'h1);
    checkVal("t3_ovf_busy", 32'(busy), 32'h1);
    checkVal("t3_ovf_data", wr_data, 32'h0FEDCBA9);

    // Flush: immediate, pending behind a held word, and coincident with a nibble
    doReset();
    wr_ready = 1'b1;
    sendNib(4'hA);
    sendNib(4'hB);
    sendNib(4'hC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("t4_flush_valid", 32'(wr_valid), 32'h1);
    checkVal("t4_flush_data", wr_data, 32'h00000CBA);
    checkVal("t4_flush_busy", 32'(busy), 32'h0);
    wr_ready = 1'b0;
    sendNib(4'h1);
    sendNib(4'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("t4_pend_busy", 32'(busy), 32'h1);
    checkVal("t4_pend_data", wr_data, 32'h00000CBA);
    checkVal("t4_pend_ovf0", 32'(overflow), 32'h0);
    sendNib(4'h5);
    checkVal("t4_pend_drop", 32'(overflow), 32'h1);
    wr_ready = 1'b1;
    tick();
    checkVal("t4_pend_valid", 32'(wr_valid), 32'h1);
    checkVal("t4_pend_emit", wr_data, 32'h00000021);
    checkVal("t4_pend_addr", 32'(wr_addr), 32'h1);
    checkVal("t4_pend_done", 32'(busy), 32'h0);
    I       = 4'h3;
    I_valid = 1'b1;
    flush   = 1'b1;
    tick();
    I_valid = 1'b0;
    flush   = 1'b0;
    checkVal("t4_co_data", wr_data, 32'h00000003);
    checkVal("t4_co_addr", 32'(wr_addr), 32'h2);
    checkVal("t4_co_busy", 32'(busy), 32'h0);

    // Address wrap over 2**ADDR_W + 1 words, then increment disabled
    doReset();
    ConfigBits = 2'b10;
    for (int w = 0; w <= 1024; w++) begin
      for (int k = 0; k < 8; k++) sendNib(4'h5);
      if (w == 1023) checkVal("t5_addr_top", 32'(wr_addr), 32'd1023);
      if (w == 1024) begin
        checkVal("t5_addr_wrap", 32'(wr_addr), 32'h0);
        checkVal("t5_data", wr_data, 32'h55555555);
      end
    end
    tick();
    checkVal("t5_addr_after", 32'(wr_addr), 32'h1);
    doReset();
    ConfigBits = 2'b00;
    for (int k = 0; k < 16; k++) sendNib(4'h1);
    checkVal("t5_noinc_addr", 32'(wr_addr), 32'h0);
    tick();
    checkVal("t5_noinc_after", 32'(wr_addr), 32'h0);

    // Reset mid-word with a held word
    doReset();
    ConfigBits = 2'b10;
    wr_ready   = 1'b0;
    for (int k = 0; k < 8; k++) sendNib(4'(k + 1));
    for (int k = 0; k < 3; k++) sendNib(4'hF);
    checkVal("t6_pre_valid", 32'(wr_valid), 32'h1);
    checkVal("t6_pre_busy", 32'(busy), 32'h1);
    UserRST = 1'b1;
    tick();
    checkVal("t6_rst_data", wr_data, 32'h0);
    checkVal("t6_rst_addr", 32'(wr_addr), 32'h0);
    checkVal("t6_rst_valid", 32'(wr_valid), 32'h0);
    checkVal("t6_rst_busy", 32'(busy), 32'h0);
    checkVal("t6_rst_ovf", 32'(overflow), 32'h0);
    UserRST  = 1'b0;
    wr_ready = 1'b1;
    for (int k = 0; k < 8; k++) sendNib(4'(8 - k));
    checkVal("t6_fresh_data", wr_data, 32'h12345678);
    checkVal("t6_fresh_addr", 32'(wr_addr), 32'h0);
    checkVal("t6_fresh_valid", 32'(wr_valid), 32'h1);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
